// File: rtl/tdc_power_sequencer_if.sv
// Command/status bundle between the UART front end and the TDC power sequencer.
// Latency: none (wires only).
// Backpressure: none; new_rx_data is a one-cycle strobe and the sequencer always accepts it.
interface tdc_power_sequencer_if #(
  parameter int NUM_CH = 6
);
  logic [7:0]        rx_data;
  logic              new_rx_data;
  logic [NUM_CH-1:0] tdc_enable;
  logic [NUM_CH-1:0] soft_reset;
  logic              go_home;
  logic              pause;
  logic              busy;
  logic              ready;
  logic [NUM_CH-1:0] ch_mask;

  modport master (
    output rx_data, new_rx_data,
    input  tdc_enable, soft_reset, go_home, pause, busy, ready, ch_mask
  );

  modport slave (
    input  rx_data, new_rx_data,
    output tdc_enable, soft_reset, go_home, pause, busy, ready, ch_mask
  );
endinterface

// File: rtl/tdc_power_sequencer.sv
// UART-command power-up / soft-reset sequencer for a bank of TDC front-end channels.
// Latency: a command strobed in cycle N shows on the registered outputs after edge N+1.
// Backpressure: none; every strobed byte is consumed, commands not valid in the current state are dropped.
module tdc_power_sequencer #(
  parameter int NUM_CH       = 6,
  parameter int OFF_CYCLES   = 1000,
  parameter int BOOT_CYCLES  = 1000000,
  parameter int RESET_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  tdc_power_sequencer_if.slave  bus
);

  localparam int MAX_OB  = (OFF_CYCLES > BOOT_CYCLES) ? OFF_CYCLES : BOOT_CYCLES;
  localparam int MAX_CYC = (MAX_OB > RESET_CYCLES) ? MAX_OB : RESET_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] OFF_LD   = CNT_W'(OFF_CYCLES);
  localparam logic [CNT_W-1:0] BOOT_LD  = CNT_W'(BOOT_CYCLES);
  localparam logic [CNT_W-1:0] RESET_LD = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POWER_OFF,
    S_BOOT_WAIT,
    S_SOFT_RESET,
    S_READY
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [NUM_CH-1:0] active_mask, active_mask_nxt;

  logic              cap_flag, cap_flag_nxt;
  logic [NUM_CH-1:0] ch_mask_q, ch_mask_nxt;
  logic [NUM_CH-1:0] tdc_enable_q, tdc_enable_nxt;
  logic [NUM_CH-1:0] soft_reset_q, soft_reset_nxt;
  logic              go_home_q, go_home_nxt;
  logic              pause_q, pause_nxt;
  logic              busy_q, busy_nxt;
  logic              ready_q, ready_nxt;

  logic              cmd_vld;
  logic              cmd_d, cmd_r, cmd_h, cmd_s, cmd_p, cmd_m;
  logic [NUM_CH-1:0] mask_byte;

  // Command decode; the byte following "m" is mask data and never a command.
  always_comb begin
    cmd_vld = bus.new_rx_data & ~cap_flag;
    cmd_d   = cmd_vld & (bus.rx_data == 8'h64);
    cmd_r   = cmd_vld & (bus.rx_data == 8'h72) & ((state == S_IDLE) | (state == S_READY));
    cmd_h   = cmd_vld & (bus.rx_data == 8'h68);
    cmd_s   = cmd_vld & (bus.rx_data == 8'h73);
    cmd_p   = cmd_vld & (bus.rx_data == 8'h70);
    cmd_m   = cmd_vld & (bus.rx_data == 8'h6D);
    // Channels above bit 7 are zero-filled when the bank is wider than a byte.
    for (int i = 0; i < NUM_CH; i++) begin
      mask_byte[i] = (i < 8) ? bus.rx_data[i[2:0]] : 1'b0;
    end
  end

  // State, phase counter and latched channel set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      active_mask <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      active_mask <= active_mask_nxt;
    end
  end

  // Phase sequencing; a phase ends on the cycle its counter reads 1, and "d" overrides everything.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    active_mask_nxt = active_mask;
    case (state)
      S_POWER_OFF: begin
        if (cnt == CNT_ONE) begin
          state_nxt = S_BOOT_WAIT;
          cnt_nxt   = BOOT_LD;
        end else begin
          cnt_nxt   = cnt - CNT_ONE;
        end
      end
      S_BOOT_WAIT: begin
        if (cnt == CNT_ONE) begin
          state_nxt = S_SOFT_RESET;
          cnt_nxt   = RESET_LD;
        end else begin
          cnt_nxt   = cnt - CNT_ONE;
        end
      end
      S_SOFT_RESET: begin
        if (cnt == CNT_ONE) begin
          state_nxt = S_READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = state;
      end
    endcase
    if (cmd_d) begin
      state_nxt       = S_POWER_OFF;
      cnt_nxt         = OFF_LD;
      active_mask_nxt = ch_mask_q;
    end else if (cmd_r) begin
      state_nxt       = S_SOFT_RESET;
      cnt_nxt         = RESET_LD;
      active_mask_nxt = ch_mask_q;
    end
  end

  // Next output values derived from the next state, so registered outputs line up with the state register.
  always_comb begin
    tdc_enable_nxt = tdc_enable_q;
    soft_reset_nxt = '0;
    case (state_nxt)
      S_POWER_OFF:  tdc_enable_nxt = tdc_enable_q & ~active_mask_nxt;
      S_BOOT_WAIT:  tdc_enable_nxt = tdc_enable_q | active_mask_nxt;
      S_SOFT_RESET: soft_reset_nxt = active_mask_nxt;
      default:      tdc_enable_nxt = tdc_enable_q;
    endcase
    busy_nxt  = (state_nxt == S_POWER_OFF) | (state_nxt == S_BOOT_WAIT) |
                (state_nxt == S_SOFT_RESET);
    ready_nxt = (state_nxt == S_READY);

    go_home_nxt = go_home_q;
    if (cmd_d)      go_home_nxt = 1'b0;
    else if (cmd_h) go_home_nxt = 1'b1;

    pause_nxt = pause_q;
    if (cmd_s)      pause_nxt = 1'b1;
    else if (cmd_p) pause_nxt = 1'b0;

    ch_mask_nxt  = ch_mask_q;
    cap_flag_nxt = cap_flag;
    if (bus.new_rx_data & cap_flag) begin
      ch_mask_nxt  = mask_byte;
      cap_flag_nxt = 1'b0;
    end else if (cmd_m) begin
      cap_flag_nxt = 1'b1;
    end
  end

  // Output and mask registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tdc_enable_q <= '0;
      soft_reset_q <= '0;
      go_home_q    <= 1'b0;
      pause_q      <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
      ch_mask_q    <= '1;
      cap_flag     <= 1'b0;
    end else begin
      tdc_enable_q <= tdc_enable_nxt;
      soft_reset_q <= soft_reset_nxt;
      go_home_q    <= go_home_nxt;
      pause_q      <= pause_nxt;
      busy_q       <= busy_nxt;
      ready_q      <= ready_nxt;
      ch_mask_q    <= ch_mask_nxt;
      cap_flag     <= cap_flag_nxt;
    end
  end

  assign bus.tdc_enable = tdc_enable_q;
  assign bus.soft_reset = soft_reset_q;
  assign bus.go_home    = go_home_q;
  assign bus.pause      = pause_q;
  assign bus.busy       = busy_q;
  assign bus.ready      = ready_q;
  assign bus.ch_mask    = ch_mask_q;

endmodule

// File: doc/tdc_power_sequencer.md
Name: tdc_power_sequencer

Overview:
UART-command-driven power-up and soft-reset sequencer for a parametrised bank of TDC front-end channels. It decodes single-byte commands from the UART receiver and drives per-channel TDC enable and soft-reset lines through a timed enable-low / boot-wait / reset-pulse sequence. It also holds the go_home and pause flags for the motion and laser logic. A channel mask, loaded over UART, selects which channels a sequence touches.

Parameters:
NUM_CH, 6, number of TDC channels (1..16)
OFF_CYCLES, 1000, cycles enable is held low before re-enable (>=1)
BOOT_CYCLES, 1000000, cycles waited after enable rises before soft reset (>=1; TDC boot is ~1.7 ms)
RESET_CYCLES, 1, width of the soft-reset pulse in cycles (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_data  input  8  received UART byte
new_rx_data  input  1  one-cycle strobe; rx_data valid
tdc_enable  output  NUM_CH  per-channel TDC enable
soft_reset  output  NUM_CH  per-channel soft-reset pulse
go_home  output  1  request scanner return to home
pause  output  1  pause / laser-off flag
busy  output  1  high in POWER_OFF, BOOT_WAIT, SOFT_RESET
ready  output  1  high in READY (sequence completed, not since restarted)
ch_mask  output  NUM_CH  current channel mask register

Behaviour:
- Reset, synchronous, on rst high at a clk edge: tdc_enable=0, soft_reset=0, go_home=0, pause=0, busy=0, ready=0, ch_mask=all ones, state=IDLE, mask-capture flag cleared. Reset mid-sequence aborts it immediately.
- All outputs are registered. A command strobed in cycle N takes effect at edge N+1.
- Commands (evaluated only when new_rx_data=1 and the mask-capture flag is clear):
  - "d": set active_mask=ch_mask, clear go_home, ready=0, enter POWER_OFF, load counter. Accepted in any state; mid-sequence it restarts from POWER_OFF.
  - "r": only in IDLE or READY. Set active_mask=ch_mask, ready=0, enter SOFT_RESET. Ignored while busy.
  - "h": go_home=1. "s": pause=1. "p": pause=0. None of these affect the state machine.
  - "m": set the mask-capture flag. The next strobed byte, of any value including command characters, is written as ch_mask = rx_data[NUM_CH-1:0] (NUM_CH>8: zero-extended). That byte is not decoded as a command. The flag then clears.
  - Any other byte is ignored.
- ch_mask changes never alter a running sequence. active_mask is latched only at "d"/"r" acceptance.
- States:
  - IDLE: no channel driven by the sequencer.
  - POWER_OFF: tdc_enable[i]=0 for active_mask[i]=1. Lasts exactly OFF_CYCLES cycles, then BOOT_WAIT.
  - BOOT_WAIT: tdc_enable[i]=1 for active bits. Lasts exactly BOOT_CYCLES cycles, then SOFT_RESET.
  - SOFT_RESET: soft_reset[i]=1 for active bits. Lasts exactly RESET_CYCLES cycles, then READY.
  - READY: soft_reset=0, ready=1. Remains until "d", "r" or rst.
- Unmasked channels: tdc_enable holds its previous value and soft_reset stays 0 throughout.
- soft_reset is 0 outside SOFT_RESET.
- Counter:
  - Width = clog2(max(OFF_CYCLES, BOOT_CYCLES, RESET_CYCLES)+1).
  - Loaded with the phase length on phase entry; decrements each cycle; phase exits on the cycle it reads 1.
  - No wrap-around permitted.
- Timing from "d" strobed at cycle N, with O, B, R the phase lengths:
  - enable low over cycles N+1..N+O.
  - enable high from N+O+1.
  - soft_reset high over N+O+B+1..N+O+B+R.
  - ready=1 from N+O+B+R+1.
- Simultaneous events: a "d" strobed on a phase's final cycle wins; the sequence restarts.
- active_mask=0: the sequence still runs with identical timing and busy/ready behaviour, but no channel lines move.

Test Plan:
- NUM_CH=6, O=4, B=10, R=2. After rst, send "d" at cycle 0 -> busy=1 at cycle 1. tdc_enable=6'h00 over cycles 1-4. tdc_enable=6'h3F from cycle 5. soft_reset=6'h3F over cycles 15-16. ready=1 and busy=0 from cycle 17.
- Send "m" then byte 8'h05, then "d" -> ch_mask=6'h05. Only channels 0 and 2 toggle enable and reset. Channels 1, 3, 4, 5 keep enable=0 and soft_reset=0.
- Send "m" then "d" -> ch_mask=6'h24 ("d"=8'h64, low 6 bits). No sequence starts and busy stays 0.
- Send "d", then a second "d" at cycle 8 (during BOOT_WAIT) -> enable drops at cycle 9 and the sequence restarts. soft_reset does not pulse at cycles 15-16; it pulses at cycles 23-24.
- Send "r" during BOOT_WAIT -> ignored. Send "r" in READY -> soft_reset=6'h3F for 2 cycles starting the next edge, ready=0 then 1, tdc_enable unchanged.
- go_home/pause: "h" -> go_home=1. "s" -> pause=1. "d" -> go_home=0, pause stays 1. "p" -> pause=0. Assert rst mid-BOOT_WAIT -> all outputs return to reset values at the next edge and ch_mask=6'h3F.
